// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : weight_loader
// Purpose  : Burst sequencer that turns 16-bit weight streams into 32-bit
//            address/data commands for the weight memory, plus read sweeps.
// Options  : WEIGHT_LOADER_CHECKSUM_EN enables the running write checksum.
// Revision : 1.0 - initial release
// ============================================================================
module weight_loader #(
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [9:0]  bank_sel,
  input  logic [19:0] base_addr,
  input  logic [19:0] count,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] checksum
);

  localparam logic [9:0]  c_num_banks = 10'(NUM_BANKS);
  localparam logic [19:0] c_last_addr = 20'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t      r_state;
  logic [9:0]  r_bank;
  logic [19:0] r_cur;
  logic [19:0] r_rem;

  logic        w_bad;
  logic        w_accept;
  logic        w_wr_hs;
  logic [19:0] w_cur_next;

  assign w_bad      = (bank_sel >= c_num_banks) || (base_addr > c_last_addr);
  assign w_accept   = (r_state == S_IDLE) && start && !w_bad;
  assign w_wr_hs    = (r_state == S_WRITE) && in_valid && in_ready;
  assign w_cur_next = (r_cur == c_last_addr) ? 20'd0 : r_cur + 20'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bank   <= '0;
      r_cur    <= '0;
      r_rem    <= '0;
      address  <= '0;
      data     <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && w_bad) begin
            err <= 1'b1;
          end else if (w_accept) begin
            busy <= 1'b1;
            if (count == 20'd0) begin
              r_state <= S_FIN;
            end else begin
              r_bank <= bank_sel;
              r_cur  <= base_addr;
              r_rem  <= count;
              if (mode) begin
                r_state <= S_READ;
              end else begin
                r_state  <= S_WRITE;
                in_ready <= 1'b1;
              end
            end
          end
        end
        S_WRITE: begin
          if (w_wr_hs) begin
            address <= {2'b01, r_bank, r_cur};
            data    <= {16'h0000, in_data};
            r_cur   <= w_cur_next;
            r_rem   <= r_rem - 20'd1;
            if (r_rem == 20'd1) begin
              in_ready <= 1'b0;
              r_state  <= S_FIN;
            end
          end else begin
            // Bubble: drop the write enable, keep the last command otherwise.
            address[30] <= 1'b0;
          end
        end
        S_READ: begin
          address <= {2'b00, r_bank, r_cur};
          r_cur   <= w_cur_next;
          r_rem   <= r_rem - 20'd1;
          if (r_rem == 20'd1) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          address[30] <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (w_wr_hs) begin
      r_checksum <= r_checksum + in_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_loader
// Purpose  : Directed self-checking bench for weight_loader with a command
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [9:0]  bank_sel = '0;
  logic [19:0] base_addr = '0;
  logic [19:0] count = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic [31:0] address;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] checksum;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [63:0] q_wr[$];
  logic [31:0] q_rd[$];

  weight_loader #(.NUM_BANKS(2), .DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .bank_sel(bank_sel), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .address(address), .data(data), .busy(busy), .done(done),
    .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    return s;
`else
    return 16'h0000 & s;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Descriptor inputs are scrambled after the strobe: they must not be resampled.
  task automatic drive_start(input logic m, input logic [9:0] b, input logic [19:0] a,
                             input logic [19:0] c);
    start = 1'b1; mode = m; bank_sel = b; base_addr = a; count = c;
    tick();
    start = 1'b0; mode = ~m; bank_sel = 10'h155; base_addr = 20'hABCDE; count = 20'h7;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    check(tag, 64'(done), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // Every write-enabled command must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && address[30]) begin
      if (q_wr.size() == 0) check("extra_write", {address, data}, 64'h0);
      else check("write_cmd", {address, data}, q_wr.pop_front());
    end
  end

  initial begin
    logic [15:0] w[3];

    tick(); tick();
    check("rst_address", 64'(address), 64'h0);
    check("rst_data", 64'(data), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_checksum", 64'(checksum), 64'h0);
    reset = 1'b0;
    tick();

    // Write burst, in_valid held
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333;
    drive_start(1'b0, 10'd1, 20'd5, 20'd3);
    check("wr_busy", 64'(busy), 64'd1);
    check("wr_in_ready", 64'(in_ready), 64'd1);
    check("wr_decode_we", 64'(address[30]), 64'd0);
    for (int i = 0; i < 3; i++) q_wr.push_back({32'h40100005 + 32'(i), 16'h0, w[i]});
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = w[i];
      tick();
    end
    in_valid = 1'b0;
    check("wr_ready_drop", 64'(in_ready), 64'd0);
    check("wr_done_early", 64'(done), 64'd0);
    tick();
    check("wr_done", 64'(done), 64'd1);
    check("wr_busy_fall", 64'(busy), 64'd0);
    check("wr_bubble_we", 64'(address[30]), 64'd0);
    check("wr_checksum", 64'(checksum), 64'(exp_sum(16'h6666)));
    tick();
    check("wr_done_pulse", 64'(done), 64'd0);
    check("wr_sum_hold", 64'(checksum), 64'(exp_sum(16'h6666)));

    // Stalled stream, with an ignored start in the first gap
    drive_start(1'b0, 10'd1, 20'd5, 20'd3);
    for (int i = 0; i < 3; i++) q_wr.push_back({32'h40100005 + 32'(i), 16'h0, w[i]});
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = w[i];
      tick();
      in_valid = 1'b0;
      if (i < 2) begin
        if (i == 0) begin
          start = 1'b1; mode = 1'b1; bank_sel = 10'd0; base_addr = 20'd0; count = 20'd1;
        end
        tick();
        start = 1'b0;
        check("stall_bubble_we", 64'(address[30]), 64'd0);
        check("stall_data_hold", 64'(data), 64'(w[i]));
        tick();
        check("stall_bubble_we2", 64'(address[30]), 64'd0);
        check("stall_in_ready", 64'(in_ready), 64'd1);
      end
    end
    wait_done("stall_done");
    check("stall_checksum", 64'(checksum), 64'(exp_sum(16'h6666)));
    check("stall_sb_empty", 64'(q_wr.size()), 64'd0);
    tick();

    // Read sweep with wrap
    drive_start(1'b1, 10'd0, 20'd1022, 20'd4);
    q_rd.push_back(32'h000003FE); q_rd.push_back(32'h000003FF);
    q_rd.push_back(32'h00000000); q_rd.push_back(32'h00000001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rd_cmd", 64'(address), 64'(q_rd.pop_front()));
      check("rd_in_ready", 64'(in_ready), 64'd0);
    end
    wait_done("rd_done");
    tick();

    // Rejected descriptors and empty burst, with a live stream offered
    in_valid = 1'b1; in_data = 16'hDEAD;
    drive_start(1'b0, 10'd2, 20'd0, 20'd3);
    check("rej_bank_err", 64'(err), 64'd1);
    check("rej_bank_busy", 64'(busy), 64'd0);
    check("rej_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("rej_err_pulse", 64'(err), 64'd0);
    check("rej_busy_low", 64'(busy), 64'd0);
    drive_start(1'b0, 10'd0, 20'd1024, 20'd3);
    check("rej_addr_err", 64'(err), 64'd1);
    tick();
    drive_start(1'b0, 10'd1, 20'd0, 20'd0);
    check("cnt0_busy", 64'(busy), 64'd1);
    check("cnt0_err", 64'(err), 64'd0);
    tick();
    check("cnt0_done", 64'(done), 64'd1);
    check("cnt0_busy_fall", 64'(busy), 64'd0);
    check("cnt0_checksum", 64'(checksum), 64'h0);
    in_valid = 1'b0;
    tick();

    // Reset after the 2nd of 4 words, then a normal wrapping burst
    drive_start(1'b0, 10'd0, 20'd10, 20'd4);
    q_wr.push_back({32'h4000000A, 32'h000000A1});
    q_wr.push_back({32'h4000000B, 32'h000000B2});
    in_valid = 1'b1;
    in_data = 16'h00A1; tick();
    in_data = 16'h00B2; tick();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_address", 64'(address), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_checksum", 64'(checksum), 64'h0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    check("post_rst_idle_we", 64'(address[30]), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    drive_start(1'b0, 10'd1, 20'd1023, 20'd3);
    q_wr.push_back({32'h401003FF, 32'h000000C1});
    q_wr.push_back({32'h40100000, 32'h000000C2});
    q_wr.push_back({32'h40100001, 32'h000000C3});
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'h00C1 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    wait_done("wrap_done");
    check("wrap_checksum", 64'(checksum), 64'(exp_sum(16'h0246)));
    tick();
    check("final_sb_empty", 64'(q_wr.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/weight_loader.md
# weight_loader

- Command sequencer directly upstream of the perceptron weight memory.
- Takes a burst descriptor (bank, base address, word count) and a valid/ready stream of 16-bit weights.
- Converts them into the 32-bit address/data command words the memory stage consumes, one per clock.
- Also provides a read-sweep mode that issues sequential read commands, so a bank can be streamed out to the layer logic.

## Interface
Parameters:
- NUM_BANKS, 2: number of RAM banks present downstream; valid bank_sel range is 0..NUM_BANKS-1.
- DEPTH, 1024: words per bank; the address counter wraps at DEPTH.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle descriptor strobe; sampled only in IDLE.
- mode  in  1  0 = write burst, 1 = read sweep.
- bank_sel  in  10  target bank, copied into command bits 29:20.
- base_addr  in  20  first word address; must be < DEPTH.
- count  in  20  number of words to write or read.
- in_valid  in  1  weight word available.
- in_data  in  16  weight word.
- in_ready  out  1  loader accepts in_data this cycle.
- address  out  32  command word: bit31 = 0, bit30 = write enable, bits29:20 = bank, bits19:0 = word address.
- data  out  32  bits15:0 = write data, bits31:16 = 0.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  one-cycle pulse when a descriptor is rejected.
- checksum  out  16  running sum of written words (see Configuration).

## Operation
- FSM states are IDLE, WRITE, READ and FIN.
- IDLE:
  - on start, check the descriptor.
  - Reject if bank_sel >= NUM_BANKS or base_addr >= DEPTH: pulse err next cycle, stay in IDLE.
  - count == 0: go to FIN (done pulse, no commands issued).
  - Otherwise latch bank, cur = base_addr and rem = count, then go to WRITE (mode 0) or READ (mode 1).
- WRITE:
  - in_ready = 1.
  - Each cycle with in_valid && in_ready: register address = {0,1,bank,cur} and data = {16'h0,in_data}, then cur = cur+1 (wrapping to 0 at DEPTH) and rem = rem-1.
  - When the accepted word takes rem to 0, go to FIN.
  - Cycles without a handshake emit a bubble: bit30 = 0, bank and cur unchanged, data held. The downstream write enable drops on any we = 0 cycle.
- READ:
  - in_ready = 0.
  - One command per cycle: {0,0,bank,cur}, advancing cur and rem the same way as WRITE.
  - Go to FIN after the count-th command.
- FIN:
  - done = 1 for exactly one cycle.
  - Emit one bubble with bit30 = 0 so the last write is not repeated.
  - Return to IDLE.
- start outside IDLE is ignored. Descriptor inputs are only sampled on the accepted start.
- Outside WRITE, bit30 is always 0.

## Timing
- Reset (async, any state, including mid-burst): state = IDLE; address = 0, data = 0, in_ready = 0, busy = 0, done = 0, err = 0, checksum = 0.
- A partially written burst is abandoned on reset; no further commands are issued.
- address and data are registered: a command appears the cycle after its input handshake (WRITE) or its counter value (READ).
- A write burst of N words with in_valid held high lasts N+2 cycles from start to done: 1 cycle decode, N commands, done coincident with the bubble.
- busy rises the cycle after an accepted start and falls on the cycle done is asserted.
- in_ready is a registered state decode. It deasserts in the cycle after the last handshake, never combinationally from in_valid.
- Wrap-around: base_addr = DEPTH-1 with count = 3 yields addresses DEPTH-1, 0, 1.

## Configuration
- WEIGHT_LOADER_CHECKSUM_EN defined:
  - checksum clears on each accepted start.
  - It adds in_data (mod 2^16) on every WRITE handshake.
  - It holds its value after done until the next start.
- Not defined: checksum is tied to 0 and the adder is not instantiated. All other behaviour is identical.

## Test plan
- Write burst: bank 1, base 5, count 3, data 0x1111/0x2222/0x3333 with in_valid held -> address 0x40100005, 0x40100006, 0x40100007 on consecutive cycles, then bit30 = 0; done one cycle; checksum 0x6666 with macro, 0 without.
- Stalled stream: same burst with in_valid low for 2 cycles between words -> exactly 3 commands with bit30 = 1, bubbles with bit30 = 0 in the gaps, addresses contiguous.
- Read sweep: mode 1, bank 0, base 1022, count 4, DEPTH 1024 -> addresses 0x000003FE, 0x000003FF, 0x00000000, 0x00000001 with bit30 = 0; in_ready stays 0.
- Rejects: bank_sel = 2 -> err pulse, busy stays 0, no commands. count = 0 -> done pulse, no command with bit30 = 1.
- Reset mid-burst: assert reset after the 2nd of 4 words -> address = 0 and busy = 0 immediately; a new start afterwards runs normally.
